// File: rtl/la_ioring_pkg.sv
// Shared definitions for the io ring configuration transmitter: FSM states,
// ioring bit positions and the pad/bit to serial-position mapping.
package la_ioring_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SYNC  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_LOAD  = 2'd3
  } state_e;

  localparam int SHIFT_EN = 0;
  localparam int SDATA    = 1;
  localparam int LOAD     = 2;
  localparam int SYNC     = 3;

  // Serial slot of a configuration bit: highest pad first, MSB first.
  function automatic int stream_pos(input int pad, input int bit_idx,
                                    input int npad, input int cfgw);
    return (npad - 1 - pad) * cfgw + (cfgw - 1 - bit_idx);
  endfunction

endpackage

// File: rtl/la_ioring_shadow.sv
// Per-pad shadow configuration registers plus the snapshot that feeds the
// serialiser; the snapshot captures the same-cycle write so it is never lost.
module la_ioring_shadow
  import la_ioring_pkg::*;
#(
  parameter int              NPAD   = 16,
  parameter int              CFGW   = 8,
  parameter int              AW     = 4,
  parameter logic [CFGW-1:0] DEFCFG = '0
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 wr_en_i,
  input  logic [AW-1:0]        wr_addr_i,
  input  logic [CFGW-1:0]      wr_data_i,
  input  logic                 snap_en_i,
  output logic [NPAD*CFGW-1:0] snap_stream_o
);

  genvar gi;
  generate
    for (gi = 0; gi < NPAD; gi++) begin : g_pad
      logic [CFGW-1:0] entry_q;
      logic [CFGW-1:0] entry_d;
      logic [CFGW-1:0] snap_q;

      // Addresses at or beyond NPAD match no entry and are silently dropped.
      assign entry_d = (wr_en_i && (wr_addr_i == AW'(gi))) ? wr_data_i : entry_q;

      always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
          entry_q <= DEFCFG;
          snap_q  <= DEFCFG;
        end else begin
          entry_q <= entry_d;
          if (snap_en_i) begin
            snap_q <= entry_d;
          end
        end
      end

      for (genvar bj = 0; bj < CFGW; bj++) begin : g_bit
        localparam int POS = stream_pos(gi, bj, NPAD, CFGW);
        assign snap_stream_o[POS] = snap_q[bj];
      end
    end
  endgenerate

endmodule

// File: rtl/la_ioring_cfgtx.sv
// Io ring configuration transmitter: collects per-pad config words and, on
// commit, plays them out as sync pulse, serial shift and load pulse.
module la_ioring_cfgtx
  import la_ioring_pkg::*;
#(
  parameter                  PROP   = "DEFAULT",
  parameter                  SIDE   = "NO",
  parameter int              RINGW  = 8,
  parameter int              NPAD   = 16,
  parameter int              CFGW   = 8,
  parameter logic [CFGW-1:0] DEFCFG = '0,
  localparam int             AW     = (NPAD > 1) ? $clog2(NPAD) : 1
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [AW-1:0]    wr_addr,
  input  logic [CFGW-1:0]  wr_data,
  input  logic             commit,
  output logic             busy,
  output logic             done,
  output logic             commit_err,
  output logic [RINGW-1:0] ioring
);

  localparam int TOT = NPAD * CFGW;
  localparam int CW  = (TOT > 1) ? $clog2(TOT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TOT - 1);

  if (RINGW < 4 || PROP == {$bits(PROP){1'b0}} ||
      (SIDE != "NO" && SIDE != "SO" && SIDE != "EA" && SIDE != "WE")) begin : g_bad_param
    $error("la_ioring_cfgtx: illegal RINGW, PROP or SIDE");
  end

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [RINGW-1:0] ioring_q, ioring_d;
  logic             busy_q, done_q, commit_err_q, wr_ready_q;
  logic             wr_en, snap_en;
  logic [TOT-1:0]   snap_stream;

  assign wr_en   = wr_valid && wr_ready_q;
  assign snap_en = commit && (state_q == ST_IDLE);

  la_ioring_shadow #(
    .NPAD   (NPAD),
    .CFGW   (CFGW),
    .AW     (AW),
    .DEFCFG (DEFCFG)
  ) u_shadow (
    .clk           (clk),
    .nreset        (nreset),
    .wr_en_i       (wr_en),
    .wr_addr_i     (wr_addr),
    .wr_data_i     (wr_data),
    .snap_en_i     (snap_en),
    .snap_stream_o (snap_stream)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE:  if (commit) state_d = ST_SYNC;
      ST_SYNC: begin
        state_d = ST_SHIFT;
        cnt_d   = '0;
      end
      ST_SHIFT: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_LOAD:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the ring sees clean flop outputs.
  always_comb begin
    ioring_d = '0;
    case (state_d)
      ST_SYNC:  ioring_d[SYNC] = 1'b1;
      ST_SHIFT: begin
        ioring_d[SHIFT_EN] = 1'b1;
        ioring_d[SDATA]    = snap_stream[cnt_d];
      end
      ST_LOAD:  ioring_d[LOAD] = 1'b1;
      default:  ioring_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      ioring_q     <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      commit_err_q <= 1'b0;
      wr_ready_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ioring_q     <= ioring_d;
      busy_q       <= (state_d != ST_IDLE);
      done_q       <= (state_q == ST_LOAD);
      commit_err_q <= commit && (state_q != ST_IDLE);
      wr_ready_q   <= (state_d == ST_IDLE);
    end
  end

  assign wr_ready   = wr_ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign commit_err = commit_err_q;
  assign ioring     = ioring_q;

endmodule
